// File: rtl/taxi_pkg.sv
// Shared types and constants for the taxi trip sequencer.
package taxi_pkg;

   localparam int DIST_W = 16;

   localparam logic [2:0] DEF_INITCOST = 3'd6;
   localparam logic [2:0] DEF_PERCOST  = 3'd2;
   localparam logic [2:0] DEF_ADDMAIL  = 3'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRESET = 3'd1,
      ST_RUN    = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DONE   = 3'd4
   } trip_state_e;

   // Distance never wraps: it sticks at all-ones once it gets there.
   function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/taxi_trip_ctrl_if.sv
// Board-side controls, tariff configuration and fare-meter drive of the trip sequencer.
// master: the board/button side; slave: taxi_trip_ctrl.
interface taxi_trip_ctrl_if;
   import taxi_pkg::*;

   logic              start;
   logic              pause;
   logic              stop;
   logic              clear;
   logic              cfg_load;
   logic [2:0]        cfg_initcost;
   logic [2:0]        cfg_percost;
   logic [2:0]        cfg_addmail;
   logic              wheel_in;

   logic              meter_rst;
   logic              meter_set;
   logic [2:0]        meter_initcost;
   logic [2:0]        meter_percost;
   logic [2:0]        meter_addmail;
   logic [DIST_W-1:0] distance;
   logic              busy;
   logic              trip_done;

   modport master (
      output start, pause, stop, clear, cfg_load,
      output cfg_initcost, cfg_percost, cfg_addmail, wheel_in,
      input  meter_rst, meter_set, meter_initcost, meter_percost, meter_addmail,
      input  distance, busy, trip_done
   );

   modport slave (
      input  start, pause, stop, clear, cfg_load,
      input  cfg_initcost, cfg_percost, cfg_addmail, wheel_in,
      output meter_rst, meter_set, meter_initcost, meter_percost, meter_addmail,
      output distance, busy, trip_done
   );

endinterface

// File: rtl/taxi_pulse_sync.sv
// Two-flop synchroniser for the raw wheel sensor followed by a rising-edge detector.
// rise is high for one clk, two edges after the raw input first rises.
module taxi_pulse_sync (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic rise
);

   // [0],[1]: synchroniser stages; [2]: previous synchronised value for edge detect
   logic [2:0] sh_q, sh_d;

   // Shift the sensor value through the synchroniser and history stage.
   always_comb begin
      sh_d = {sh_q[1:0], sig_in};
   end

   // Register the shift chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sh_q <= '0;
      else     sh_q <= sh_d;
   end

   assign rise = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/taxi_trip_ctrl.sv
// Trip sequencer for the taxi fare meter: tariff latch, trip FSM and wheel-pulse distance count.
// Optional waiting-time fare: define WAIT_FARE_EN.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | meter held (meter_rst=1); tariff may be loaded; wait for start
// PRESET | one-cycle meter_set strobe; distance and prescaler cleared
// RUN    | counted wheel edges advance prescaler and distance
// WAIT   | passenger wait; wheel ignored, prescaler held
// DONE   | trip over; distance frozen until clear returns to IDLE
module taxi_trip_ctrl
   import taxi_pkg::*;
#(
   parameter int PULSES_PER_UNIT = 10,
   parameter int WAIT_TICKS      = 50000
) (
   input  logic            clk,
   input  logic            rst,
   taxi_trip_ctrl_if.slave bus
);

   localparam int PRE_W = (PULSES_PER_UNIT > 1) ? $clog2(PULSES_PER_UNIT) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PULSES_PER_UNIT - 1);

   if (PULSES_PER_UNIT < 1 || WAIT_TICKS < 1) begin : g_param_chk
      $error("taxi_trip_ctrl: PULSES_PER_UNIT and WAIT_TICKS must be >= 1");
   end

   trip_state_e       state_q, state_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [DIST_W-1:0] dist_q, dist_d;
   logic [2:0]        initcost_q, initcost_d;
   logic [2:0]        percost_q, percost_d;
   logic [2:0]        addmail_q, addmail_d;
   logic              meter_rst_q, meter_rst_d;
   logic              meter_set_q, meter_set_d;
   logic              busy_q, busy_d;
   logic              trip_done_q, trip_done_d;
   logic              wheel_rise;

`ifdef WAIT_FARE_EN
   localparam int TICK_W = (WAIT_TICKS > 1) ? $clog2(WAIT_TICKS) : 1;
   localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(WAIT_TICKS - 1);
   logic [TICK_W-1:0] tick_q, tick_d;
`endif

   taxi_pulse_sync u_wheel_sync (
      .clk    (clk),
      .rst    (rst),
      .sig_in (bus.wheel_in),
      .rise   (wheel_rise)
   );

   // Next-state, counter and tariff logic; outputs are decoded from the next state so they register with it.
   always_comb begin
      state_d    = state_q;
      pre_d      = pre_q;
      dist_d     = dist_q;
      initcost_d = initcost_q;
      percost_d  = percost_q;
      addmail_d  = addmail_q;
`ifdef WAIT_FARE_EN
      tick_d     = tick_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.cfg_load) begin
               initcost_d = bus.cfg_initcost;
               percost_d  = bus.cfg_percost;
               addmail_d  = bus.cfg_addmail;
            end
            if (bus.start) state_d = ST_PRESET;
         end
         ST_PRESET: begin
            dist_d  = '0;
            pre_d   = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            // A wheel edge coinciding with stop/pause is dropped: the state change wins.
            if (bus.stop) begin
               state_d = ST_DONE;
            end else if (bus.pause) begin
               state_d = ST_WAIT;
`ifdef WAIT_FARE_EN
               tick_d  = '0;
`endif
            end else if (wheel_rise) begin
               if (pre_q == PRE_MAX) begin
                  pre_d  = '0;
                  dist_d = sat_inc(dist_q);
               end else begin
                  pre_d  = pre_q + 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (bus.stop) begin
               state_d = ST_DONE;
            end else begin
               if (!bus.pause) state_d = ST_RUN;
`ifdef WAIT_FARE_EN
               if (tick_q == TICK_MAX) begin
                  tick_d = '0;
                  dist_d = sat_inc(dist_q);
               end else begin
                  tick_d = tick_q + 1'b1;
               end
`endif
            end
         end
         ST_DONE: begin
            if (bus.clear) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      meter_rst_d = (state_d == ST_IDLE);
      meter_set_d = (state_d == ST_PRESET);
      busy_d      = (state_d == ST_PRESET) || (state_d == ST_RUN) || (state_d == ST_WAIT);
      trip_done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
   end

   // State, counters, tariff and registered meter drive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pre_q       <= '0;
         dist_q      <= '0;
         initcost_q  <= DEF_INITCOST;
         percost_q   <= DEF_PERCOST;
         addmail_q   <= DEF_ADDMAIL;
         meter_rst_q <= 1'b1;
         meter_set_q <= 1'b0;
         busy_q      <= 1'b0;
         trip_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pre_q       <= pre_d;
         dist_q      <= dist_d;
         initcost_q  <= initcost_d;
         percost_q   <= percost_d;
         addmail_q   <= addmail_d;
         meter_rst_q <= meter_rst_d;
         meter_set_q <= meter_set_d;
         busy_q      <= busy_d;
         trip_done_q <= trip_done_d;
      end
   end

`ifdef WAIT_FARE_EN
   // Waiting-time tick counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tick_q <= '0;
      else     tick_q <= tick_d;
   end
`endif

   assign bus.meter_rst      = meter_rst_q;
   assign bus.meter_set      = meter_set_q;
   assign bus.meter_initcost = initcost_q;
   assign bus.meter_percost  = percost_q;
   assign bus.meter_addmail  = addmail_q;
   assign bus.distance       = dist_q;
   assign bus.busy           = busy_q;
   assign bus.trip_done      = trip_done_q;

endmodule
